// File: rtl/sample_framer.sv
// Ping-pong sample framer: collects strobed samples into 16-word frames and
// streams complete frames with valid/ready. Define BIT_REVERSE_EN for bit-reversed read order.
module sample_framer #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sampling_signal,
   input  logic [DATA_W-1:0] sample_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_index,
   output logic              out_last,
   output logic              overrun
);

   logic [DATA_W-1:0] bank_q [2][16];
   logic [1:0]        full_q, full_d;
   logic              fill_sel_q, fill_sel_d;
   logic              rd_sel_q, rd_sel_d;
   logic [3:0]        wr_cnt_q, wr_cnt_d;
   logic [3:0]        rd_cnt_q, rd_cnt_d;
   logic              overrun_q, overrun_d;

   logic              xfer;
   logic              release_rd;
   logic              accept;
   logic [3:0]        rd_pos;

   function automatic logic [3:0] order(input logic [3:0] k);
`ifdef BIT_REVERSE_EN
      return {k[0], k[1], k[2], k[3]};
`else
      return k;
`endif
   endfunction

   always_comb begin
      out_valid  = full_q[rd_sel_q];
      rd_pos     = order(rd_cnt_q);
      out_data   = bank_q[rd_sel_q][rd_pos];
      // rd_cnt only moves on transfers, so it is 0 whenever out_valid is low
      out_index  = rd_pos;
      out_last   = out_valid && (rd_cnt_q == 4'd15);
      overrun    = overrun_q;

      xfer       = out_valid && out_ready;
      release_rd = xfer && (rd_cnt_q == 4'd15);
      // a bank freed on this edge may be refilled on the same edge
      accept     = sampling_signal &&
                   (!full_q[fill_sel_q] || (release_rd && (rd_sel_q == fill_sel_q)));

      full_d     = full_q;
      fill_sel_d = fill_sel_q;
      rd_sel_d   = rd_sel_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      overrun_d  = overrun_q;

      if (xfer) begin
         rd_cnt_d = rd_cnt_q + 4'd1;
         if (release_rd) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
         end
      end

      if (sampling_signal && !accept) begin
         overrun_d = 1'b1;
      end

      if (accept) begin
         wr_cnt_d = wr_cnt_q + 4'd1;
         if (wr_cnt_q == 4'd15) begin
            full_d[fill_sel_q] = 1'b1;
            fill_sel_d         = ~fill_sel_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q     <= 2'b00;
         fill_sel_q <= 1'b0;
         rd_sel_q   <= 1'b0;
         wr_cnt_q   <= 4'd0;
         rd_cnt_q   <= 4'd0;
         overrun_q  <= 1'b0;
      end else begin
         full_q     <= full_d;
         fill_sel_q <= fill_sel_d;
         rd_sel_q   <= rd_sel_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         overrun_q  <= overrun_d;
      end
   end

   // sample storage carries no reset
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         bank_q[fill_sel_q][wr_cnt_q] <= sample_in;
      end
   end

endmodule

// File: tb/tb_sample_framer.sv
// Randomized and directed bench for sample_framer against a frame-queue reference model.
module tb_sample_framer;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sampling_signal = 1'b0;
   logic [DW-1:0] sample_in = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [3:0]    out_index;
   logic          out_last;
   logic          overrun;

   sample_framer #(.DATA_W(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .sampling_signal (sampling_signal),
      .sample_in       (sample_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_index       (out_index),
      .out_last        (out_last),
      .overrun         (overrun)
   );

   always #5 clk = ~clk;

`ifdef BIT_REVERSE_EN
   int ord_t [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
   int ord_t [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef logic [DW-1:0] frame_t [16];
   frame_t pend_q[$];
   frame_t part;
   int     part_n = 0;
   int     rd_pos = 0;
   bit     m_ov = 1'b0;
   bit     rst_edge = 1'b0;
   bit     started = 1'b0;

   typedef struct {
      logic [DW-1:0] d;
      logic [3:0]    idx;
      logic          last;
      int            cyc;
   } word_t;
   word_t log_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: queue of complete frames (at most two held), one partial frame.
   always @(posedge clk) begin
      bit valid_m, rel;
      cyc++;
      started  = 1'b1;
      rst_edge = rst;
      if (rst) begin
         pend_q.delete();
         part_n = 0;
         rd_pos = 0;
         m_ov   = 1'b0;
      end else begin
         valid_m = pend_q.size() > 0;
         rel = 1'b0;
         if (valid_m && out_ready) begin
            if (rd_pos == 15) begin
               rel = 1'b1;
               void'(pend_q.pop_front());
               rd_pos = 0;
            end else begin
               rd_pos++;
            end
         end
         if (sampling_signal) begin
            if (pend_q.size() < 2) begin
               part[part_n] = sample_in;
               part_n++;
               if (part_n == 16) begin
                  pend_q.push_back(part);
                  part_n = 0;
               end
            end else begin
               m_ov = 1'b1;
            end
         end
      end
   end

   logic          p_hold = 1'b0;
   logic [DW-1:0] p_data;
   logic [3:0]    p_idx;
   logic          p_last;

   always @(negedge clk) begin
      bit mv;
      if (started) begin
         mv = pend_q.size() > 0;
         chk("valid", out_valid, mv);
         chk("overrun", overrun, m_ov);
         if (mv) begin
            chk("data", out_data, pend_q[0][ord_t[rd_pos]]);
            chk("index", out_index, ord_t[rd_pos]);
            chk("last", out_last, rd_pos == 15);
         end else begin
            chk("idle_last", out_last, 1'b0);
            chk("idle_index", out_index, 4'd0);
         end
         if (p_hold && !rst_edge) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, p_data);
            chk("hold_index", out_index, p_idx);
            chk("hold_last", out_last, p_last);
         end
         if (out_valid && out_ready) begin
            log_q.push_back('{d: out_data, idx: out_index, last: out_last, cyc: cyc});
         end
         p_hold = out_valid && !out_ready;
         p_data = out_data;
         p_idx  = out_index;
         p_last = out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      sampling_signal = 1'b0;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   task automatic strobes(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         sampling_signal = 1'b1;
         sample_in = DW'(base + k);
         tick();
      end
      sampling_signal = 1'b0;
   endtask

   initial begin
      do_reset(2);

      // reset with strobes active
      out_ready = 1'b1;
      rst = 1'b1;
      sampling_signal = 1'b1;
      sample_in = 16'h1234;
      tick();
      tick();
      rst = 1'b0;
      sampling_signal = 1'b0;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      log_q.delete();
      repeat (20) tick();
      chk("rst_no_words", log_q.size(), 0);

      // single frame, latency and order
      log_q.delete();
      for (int k = 0; k < 16; k++) begin
         sampling_signal = 1'b1;
         sample_in = DW'(k);
         if (k == 15) chk("pre_valid", out_valid, 1'b0);
         tick();
      end
      sampling_signal = 1'b0;
      chk("lat_valid", out_valid, 1'b1);
      repeat (20) tick();
      chk("frame_words", log_q.size(), 16);
      if (log_q.size() == 16) begin
         chk("second_index", log_q[1].idx, ord_t[1]);
         for (int i = 0; i < 16; i++) begin
            chk("frame_data", log_q[i].d, ord_t[i]);
            chk("frame_index", log_q[i].idx, ord_t[i]);
            chk("frame_last", log_q[i].last, i == 15);
         end
      end

      // overrun: 48 strobes while stalled
      do_reset(1);
      out_ready = 1'b0;
      log_q.delete();
      strobes(48, 0);
      chk("ovr_flag", overrun, 1'b1);
      chk("ovr_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      repeat (40) tick();
      chk("ovr_words", log_q.size(), 32);
      if (log_q.size() == 32) begin
         for (int j = 0; j < 32; j++)
            chk("ovr_data", log_q[j].d, (j / 16) * 16 + ord_t[j % 16]);
         chk("ovr_b2b", log_q[31].cyc - log_q[0].cyc, 31);
      end
      chk("ovr_sticky", overrun, 1'b1);

      // backpressure 1,0,0 pattern
      do_reset(1);
      out_ready = 1'b0;
      log_q.delete();
      strobes(16, 200);
      for (int i = 0; i < 60; i++) begin
         out_ready = (i % 3 == 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_words", log_q.size(), 16);
      if (log_q.size() == 16) begin
         for (int i = 0; i < 16; i++)
            chk("bp_data", log_q[i].d, 200 + ord_t[i]);
      end

      // mid-fill reset
      do_reset(1);
      out_ready = 1'b1;
      strobes(7, 50);
      do_reset(1);
      log_q.delete();
      strobes(16, 100);
      repeat (20) tick();
      chk("mfr_words", log_q.size(), 16);
      if (log_q.size() == 16) begin
         for (int i = 0; i < 16; i++)
            chk("mfr_data", log_q[i].d, 100 + ord_t[i]);
      end

      // randomized traffic with occasional reset
      do_reset(1);
      for (int i = 0; i < 6000; i++) begin
         int mode;
         mode = (i / 500) % 4;
         sampling_signal = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         sample_in = DW'($urandom);
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) == 0);
            default: out_ready = $urandom_range(0, 1);
         endcase
         rst = ($urandom_range(0, 799) == 0);
         tick();
      end
      rst = 1'b0;
      sampling_signal = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port sampling_signal  input  1  one-cycle sample strobe from the periodic sampling-clock generator.
REQ-005 SHALL have port sample_in  input  DATA_W  sample value, valid in any cycle where sampling_signal=1.
REQ-006 SHALL have port out_valid  output  1  frame-stream data valid.
REQ-007 SHALL have port out_ready  input  1  downstream (FFT) accepts the current word.
REQ-008 SHALL have port out_data  output  DATA_W  frame sample.
REQ-009 SHALL have port out_index  output  4  storage position (0..15) of out_data within its frame.
REQ-010 SHALL have port out_last  output  1  high with the 16th word of a frame.
REQ-011 SHALL have port overrun  output  1  sticky flag: at least one strobe was dropped.

Function
REQ-012 SHALL hold two 16-entry banks (A, B) with per-bank full flags; fill_sel selects the bank being written, rd_sel the bank being drained; both start at A.
REQ-013 SHALL, on a cycle with sampling_signal=1 and fill bank not full, write sample_in at wr_cnt and increment wr_cnt (4 bits).
REQ-014 SHALL, on the write at wr_cnt=15, set that bank's full flag, wrap wr_cnt to 0 and toggle fill_sel on the same edge.
REQ-015 SHALL, on a strobe while the fill bank is full and not being released that cycle, drop the sample, leave wr_cnt unchanged and set overrun.
REQ-016 SHALL accept a strobe arriving in the same cycle its target bank is released per REQ-020, because release takes priority.
REQ-017 SHALL drive out_valid = full[rd_sel], so out_valid first rises the cycle after the 16th write (latency 1 clk).
REQ-018 SHALL drive out_data combinationally from bank[rd_sel] at position order(rd_cnt), with out_index = order(rd_cnt) and out_last = out_valid and rd_cnt=15.
REQ-019 SHALL advance rd_cnt only on out_valid and out_ready, and SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on transfer with rd_cnt=15, clear full[rd_sel], toggle rd_sel and reset rd_cnt to 0; a full other bank streams on the next cycle with no gap.
REQ-021 SHALL allow filling and draining to proceed concurrently on opposite banks at full rate.
REQ-022 SHALL never emit a partial frame.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, clear wr_cnt, rd_cnt, both full flags, fill_sel, rd_sel and overrun.
REQ-024 SHALL force out_valid=0, out_last=0, out_index=0 and overrun=0 after reset; bank contents are not reset and out_data is don't-care while out_valid=0.
REQ-025 SHALL, when reset is asserted mid-fill or mid-drain, discard all partial and pending frames.

Configuration
REQ-026 SHALL, with macro BIT_REVERSE_EN defined, use order(k) = bit-reverse of the 4-bit k, giving read sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 for radix-2 DIT FFT input.
REQ-027 SHALL, without BIT_REVERSE_EN, use order(k) = k (natural order); all other behaviour is identical.

Verification
REQ-028 SHALL verify reset: assert rst 2 cycles with strobes active -> out_valid=0, overrun=0, no words emitted.
REQ-029 SHALL verify natural order (macro off): 16 strobes with sample_in=k (k=0..15), out_ready=1 -> out_valid rises 1 clk after the 16th strobe; data/index 0..15; out_last on the 16th word only.
REQ-030 SHALL verify bit-reversed order (BIT_REVERSE_EN): same stimulus -> out_index and out_data follow 0,8,4,12,...,7,15; out_last on the word with index 15.
REQ-031 SHALL verify overrun: out_ready=0, 48 strobes with values 0..47 -> banks hold 0..15 and 16..31, samples 32..47 dropped, overrun=1; then out_ready=1 -> 32 words 0..31 back-to-back, overrun stays 1.
REQ-032 SHALL verify backpressure: out_ready toggled 1,0,0,1,... during a drain -> each word held stable while stalled, no word lost or duplicated.
REQ-033 SHALL verify mid-fill reset: 7 strobes, then rst for 1 cycle, then 16 strobes with values 100..115 -> exactly one frame 100..115 emitted.
